matrix_result_reader_pcpi: RTL and testbench

MATRIX_RESULT_READER_PCPI -- requirements
Module: matrix_result_reader_pcpi

---
 rtl/matrix_result_reader_pcpi.sv | 223 ++++++++++++++++++++++
 tb/tb_matrix_result_reader_pcpi.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_reader_pcpi.sv
// matrix_result_reader_pcpi
// Latches one 3x3 result from the matrix stage, scans it for the index of
// the largest signed sum (one element per cycle), and exposes the sums,
// a status word and the argmax/popcount through a PCPI co-processor port.
module matrix_result_reader_pcpi #(
  parameter logic [6:0] OPCODE = 7'b0001011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         res_valid,
  input  logic [8:0]   res_bits,
  input  logic [287:0] res_sums,
  input  logic         pcpi_valid,
  input  logic [31:0]  pcpi_insn,
  output logic         pcpi_wr,
  output logic [31:0]  pcpi_rd,
  output logic         pcpi_wait,
  output logic         pcpi_ready,
  output logic         res_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] F_SUM    = 3'b001;
  localparam logic [2:0] F_STATUS = 3'b010;
  localparam logic [2:0] F_ARGMAX = 3'b011;
  localparam logic [2:0] F_CLEAR  = 3'b100;

  state_t state;
  state_t state_next;

  logic [8:0]         bits_buf;
  logic signed [31:0] sums_buf [9];
  logic [3:0]         idx;
  logic signed [31:0] max_val;
  logic [3:0]         max_idx;
  logic               result_valid;
  logic               overrun;
  logic               pending;

  logic [2:0]         funct3;
  logic [4:0]         addr;
  logic               accept;
  logic               clear_acc;
  logic               capture;
  logic               overrun_hit;
  logic               scan_last;

  logic signed [31:0] cur_sum;
  logic               take_cur;
  logic signed [31:0] max_next;
  logic [3:0]         max_idx_next;

  logic [3:0]         popcount;
  logic [31:0]        status_word;
  logic [31:0]        argmax_word;
  logic [31:0]        argmax_final;
  logic [31:0]        sum_word;

  logic               unused_insn;

  assign unused_insn = ^pcpi_insn[31:15];
  assign res_busy    = (state == SCAN);

  // Instruction decode and the per-cycle events that steer the FSM and buffers.
  // A response in flight (pending wait or the ready pulse itself) blocks a new
  // acceptance, so a held pcpi_valid during the ready cycle is not re-issued.
  always_comb begin
    funct3      = pcpi_insn[14:12];
    addr        = pcpi_insn[11:7];
    accept      = 1'b0;
    if (pcpi_valid && (pcpi_insn[6:0] == OPCODE) && !pending && !pcpi_ready) begin
      accept = (funct3 == F_SUM) || (funct3 == F_STATUS) ||
               (funct3 == F_ARGMAX) || (funct3 == F_CLEAR);
    end
    clear_acc   = accept && (funct3 == F_CLEAR);
    capture     = res_valid && (state != SCAN) && !clear_acc;
    overrun_hit = res_valid && (state == SCAN) && !clear_acc;
    scan_last   = (state == SCAN) && (idx == 4'd8);
  end

  // Running-maximum comparator; the first element always seeds the maximum and
  // a strict greater-than keeps the lower index on ties.
  always_comb begin
    cur_sum      = sums_buf[idx];
    take_cur     = (idx == 4'd0) || (cur_sum > max_val);
    max_next     = take_cur ? cur_sum : max_val;
    max_idx_next = take_cur ? idx : max_idx;
  end

  // Read-data words: popcount of the latched bits, status, argmax and sum lookup.
  always_comb begin
    popcount = 4'd0;
    for (int k = 0; k < 9; k++) begin
      popcount = popcount + {3'd0, bits_buf[k]};
    end
    status_word  = {20'd0, (state == SCAN), overrun, result_valid, bits_buf};
    argmax_word  = {24'd0, popcount, max_idx};
    argmax_final = {24'd0, popcount, max_idx_next};
    sum_word     = 32'd0;
    if (addr < 5'd9) begin
      sum_word = sums_buf[addr[3:0]];
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state: a clear always returns to IDLE, a capture starts a scan,
  // and the scan ends after the ninth element.
  always_comb begin
    state_next = state;
    if (clear_acc) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (capture) state_next = SCAN;
        DONE:    if (capture) state_next = SCAN;
        SCAN:    if (idx == 4'd8) state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Result buffers, scan index, running maximum and the valid/overrun flags.
  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      bits_buf     <= 9'd0;
      for (int k = 0; k < 9; k++) begin
        sums_buf[k] <= 32'sd0;
      end
      idx          <= 4'd0;
      max_val      <= 32'sd0;
      max_idx      <= 4'd0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (capture) begin
        bits_buf     <= res_bits;
        for (int k = 0; k < 9; k++) begin
          sums_buf[k] <= res_sums[32*k +: 32];
        end
        idx          <= 4'd0;
        result_valid <= 1'b0;
      end
      if (overrun_hit) begin
        overrun <= 1'b1;
      end
      if (state == SCAN) begin
        max_val <= max_next;
        max_idx <= max_idx_next;
        idx     <= idx + 4'd1;
        if (scan_last) begin
          result_valid <= 1'b1;
        end
      end
    end
  end

  // PCPI response: registered one-cycle ready pulse, or a held wait for an
  // argmax request that arrives mid-scan, released on the scan's final edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= 32'd0;
      pcpi_wait  <= 1'b0;
      pending    <= 1'b0;
    end else begin
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= 32'd0;
      if (pending) begin
        if (scan_last) begin
          pending    <= 1'b0;
          pcpi_wait  <= 1'b0;
          pcpi_ready <= 1'b1;
          pcpi_wr    <= 1'b1;
          pcpi_rd    <= argmax_final;
        end
      end else if (accept) begin
        case (funct3)
          F_SUM: begin
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            pcpi_rd    <= sum_word;
          end
          F_STATUS: begin
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            pcpi_rd    <= status_word;
          end
          F_ARGMAX: begin
            if ((state == SCAN) && !scan_last) begin
              pending   <= 1'b1;
              pcpi_wait <= 1'b1;
            end else begin
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              pcpi_rd    <= scan_last ? argmax_final : argmax_word;
            end
          end
          F_CLEAR: begin
            pcpi_ready <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_result_reader_pcpi.sv
// tb_matrix_result_reader_pcpi
// Table of PCPI requests against a known result, hand-written multi-cycle
// sequences, and randomized results checked against a simple array model.
module tb_matrix_result_reader_pcpi;

  localparam logic [6:0] OP = 7'b0001011;

  logic         clk = 1'b0;
  logic         rst;
  logic         res_valid;
  logic [8:0]   res_bits;
  logic [287:0] res_sums;
  logic         pcpi_valid;
  logic [31:0]  pcpi_insn;
  logic         pcpi_wr;
  logic [31:0]  pcpi_rd;
  logic         pcpi_wait;
  logic         pcpi_ready;
  logic         res_busy;

  int total = 0;
  int bad   = 0;
  int cnt   = 0;

  int         m_sums [9];
  logic [8:0] m_bits;
  logic       m_overrun;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  addr;
    bit          resp;
    logic [31:0] rd;
    logic        wr;
  } vec_t;

  vec_t tbl[$];

  matrix_result_reader_pcpi #(.OPCODE(OP)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_bits(res_bits), .res_sums(res_sums),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait),
    .pcpi_ready(pcpi_ready), .res_busy(res_busy)
  );

  always #5 clk = ~clk;

  // Count rising edges so latencies can be measured in whole cycles.
  always @(posedge clk) cnt <= cnt + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] addr,
                              input bit resp, input logic [31:0] rd, input logic wr);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.resp = resp; v.rd = rd; v.wr = wr;
    return v;
  endfunction

  function automatic logic [287:0] pack_sums();
    logic [287:0] p;
    p = '0;
    for (int k = 0; k < 9; k++) p[32*k +: 32] = 32'(m_sums[k]);
    return p;
  endfunction

  // Argmax as a plain search: first strictly-greater value wins.
  function automatic logic [31:0] exp_argmax();
    int best;
    best = 0;
    for (int i = 1; i < 9; i++) if (m_sums[i] > m_sums[best]) best = i;
    return {24'd0, 4'($countones(m_bits)), 4'(best)};
  endfunction

  function automatic logic [31:0] exp_sum(input int a);
    return (a < 9) ? 32'(m_sums[a]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_status();
    return {20'd0, 1'b0, m_overrun, 1'b1, m_bits};
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 9; k++) m_sums[k] = 0;
    m_bits    = 9'd0;
    m_overrun = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Present one result for a single cycle; starts and ends on a falling edge.
  task automatic applyStimulus(input logic [8:0] bits, input logic [287:0] sums, output int cap_at);
    res_valid = 1'b1;
    res_bits  = bits;
    res_sums  = sums;
    cap_at    = cnt + 1;
    @(negedge clk);
    res_valid = 1'b0;
  endtask

  // Offer one instruction until ready or the budget runs out, then confirm
  // the ready pulse lasted one cycle.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] addr,
                       input int budget, output bit got, output logic [31:0] rd,
                       output logic wr, output int acc_at, output int rdy_at, output int waits);
    pcpi_valid = 1'b1;
    pcpi_insn  = {17'd0, f3, addr, op};
    acc_at     = cnt + 1;
    rdy_at     = -1;
    got        = 1'b0;
    waits      = 0;
    rd         = '0;
    wr         = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pcpi_ready) begin
        got = 1'b1; rd = pcpi_rd; wr = pcpi_wr; rdy_at = cnt;
        break;
      end
      if (pcpi_wait) waits++;
    end
    pcpi_valid = 1'b0;
    if (got) begin
      @(negedge clk);
      checkOutput("ready_pulse", {31'd0, pcpi_ready}, 32'd0);
    end
  endtask

  task automatic do_clear();
    bit got; logic [31:0] rd; logic wr; int a, r, w;
    issue(OP, 3'b100, 5'd0, 4, got, rd, wr, a, r, w);
    checkOutput("clear_ready", {31'd0, got}, 32'd1);
    checkOutput("clear_wr", {31'd0, wr}, 32'd0);
    model_clear();
  endtask

  initial begin
    bit got; logic [31:0] rd; logic wr; int acc, rdy, waits, cap, dummy, exp_rdy;
    int seen;
    logic [287:0] junk;

    rst = 1'b1; res_valid = 1'b0; res_bits = '0; res_sums = '0;
    pcpi_valid = 1'b0; pcpi_insn = '0;
    model_clear();

    // Reset: every output reads zero while rst is held.
    repeat (3) @(negedge clk);
    checkOutput("rst_wr", {31'd0, pcpi_wr}, 32'd0);
    checkOutput("rst_rd", pcpi_rd, 32'd0);
    checkOutput("rst_wait", {31'd0, pcpi_wait}, 32'd0);
    checkOutput("rst_ready", {31'd0, pcpi_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, res_busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table: requests against the reference result once the scan is done.
    m_sums = '{5, -3, 40, 40, 0, -7, 2, 1, 9};
    m_bits = 9'h1A5;
    applyStimulus(m_bits, pack_sums(), cap);
    checkOutput("busy_scan", {31'd0, res_busy}, 32'd1);
    repeat (10) @(negedge clk);
    checkOutput("busy_done", {31'd0, res_busy}, 32'd0);

    tbl.push_back(mk(OP, 3'b011, 5'd0,  1'b1, 32'h0000_0052, 1'b1));
    tbl.push_back(mk(OP, 3'b001, 5'd5,  1'b1, 32'hFFFF_FFF9, 1'b1));
    tbl.push_back(mk(OP, 3'b001, 5'd0,  1'b1, exp_sum(0), 1'b1));
    tbl.push_back(mk(OP, 3'b001, 5'd2,  1'b1, exp_sum(2), 1'b1));
    tbl.push_back(mk(OP, 3'b001, 5'd8,  1'b1, exp_sum(8), 1'b1));
    tbl.push_back(mk(OP, 3'b001, 5'd9,  1'b1, 32'd0, 1'b1));
    tbl.push_back(mk(OP, 3'b001, 5'd12, 1'b1, 32'd0, 1'b1));
    tbl.push_back(mk(OP, 3'b001, 5'd31, 1'b1, 32'd0, 1'b1));
    tbl.push_back(mk(OP, 3'b010, 5'd0,  1'b1, 32'h0000_03A5, 1'b1));
    tbl.push_back(mk(OP, 3'b000, 5'd1,  1'b0, 32'd0, 1'b0));
    tbl.push_back(mk(OP, 3'b101, 5'd1,  1'b0, 32'd0, 1'b0));
    tbl.push_back(mk(OP, 3'b110, 5'd1,  1'b0, 32'd0, 1'b0));
    tbl.push_back(mk(OP, 3'b111, 5'd1,  1'b0, 32'd0, 1'b0));
    tbl.push_back(mk(7'b0101011, 3'b001, 5'd1, 1'b0, 32'd0, 1'b0));

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].f3, tbl[i].addr, 4, got, rd, wr, acc, rdy, waits);
      checkOutput($sformatf("tbl%0d_ready", i), {31'd0, got}, {31'd0, tbl[i].resp});
      if (tbl[i].resp) begin
        checkOutput($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
        checkOutput($sformatf("tbl%0d_wr", i), {31'd0, wr}, {31'd0, tbl[i].wr});
        checkOutput($sformatf("tbl%0d_lat", i), 32'(rdy - acc), 32'd0);
      end else begin
        checkOutput($sformatf("tbl%0d_wait", i), 32'(waits), 32'd0);
      end
    end

    // pcpi_valid held through the ready cycle must not start a second request.
    pcpi_valid = 1'b1;
    pcpi_insn  = {17'd0, 3'b010, 5'd0, OP};
    @(negedge clk);
    checkOutput("hold_first_ready", {31'd0, pcpi_ready}, 32'd1);
    @(negedge clk);
    checkOutput("hold_no_second", {31'd0, pcpi_ready}, 32'd0);
    checkOutput("hold_no_wait", {31'd0, pcpi_wait}, 32'd0);
    pcpi_valid = 1'b0;
    @(negedge clk);

    // Early argmax: wait held until the scan finishes, then one ready pulse.
    do_clear();
    m_sums = '{5, -3, 40, 40, 0, -7, 2, 1, 9};
    m_bits = 9'h1A5;
    applyStimulus(m_bits, pack_sums(), cap);
    issue(OP, 3'b011, 5'd0, 20, got, rd, wr, acc, rdy, waits);
    checkOutput("early_ready", {31'd0, got}, 32'd1);
    checkOutput("early_rd", rd, 32'h0000_0052);
    checkOutput("early_wr", {31'd0, wr}, 32'd1);
    checkOutput("early_rdy_at", 32'(rdy), 32'(cap + 9));
    checkOutput("early_waits", 32'(waits), 32'(cap + 9 - acc));

    // Overrun: a second result three cycles into the scan is ignored.
    do_clear();
    m_sums = '{5, -3, 40, 40, 0, -7, 2, 1, 9};
    m_bits = 9'h1A5;
    applyStimulus(m_bits, pack_sums(), cap);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 9; k++) junk[32*k +: 32] = 32'(100 + k);
    applyStimulus(9'h04A, junk, dummy);
    m_overrun = 1'b1;
    repeat (10) @(negedge clk);
    issue(OP, 3'b001, 5'd5, 4, got, rd, wr, acc, rdy, waits);
    checkOutput("ovr_sum5", rd, 32'hFFFF_FFF9);
    issue(OP, 3'b010, 5'd0, 4, got, rd, wr, acc, rdy, waits);
    checkOutput("ovr_status", rd, 32'h0000_07A5);
    issue(OP, 3'b011, 5'd0, 4, got, rd, wr, acc, rdy, waits);
    checkOutput("ovr_argmax", rd, 32'h0000_0052);
    do_clear();
    issue(OP, 3'b010, 5'd0, 4, got, rd, wr, acc, rdy, waits);
    checkOutput("ovr_status_cleared", rd, 32'd0);

    // Clear and capture on the same edge, first from DONE then from SCAN.
    for (int pass = 0; pass < 2; pass++) begin
      m_sums = '{5, -3, 40, 40, 0, -7, 2, 1, 9};
      m_bits = 9'h1A5;
      applyStimulus(m_bits, pack_sums(), cap);
      repeat (pass == 0 ? 10 : 1) @(negedge clk);
      res_valid  = 1'b1;
      res_bits   = 9'h1FF;
      res_sums   = junk;
      pcpi_valid = 1'b1;
      pcpi_insn  = {17'd0, 3'b100, 5'd0, OP};
      @(negedge clk);
      res_valid  = 1'b0;
      checkOutput($sformatf("cc%0d_ready", pass), {31'd0, pcpi_ready}, 32'd1);
      checkOutput($sformatf("cc%0d_wr", pass), {31'd0, pcpi_wr}, 32'd0);
      pcpi_valid = 1'b0;
      seen = 0;
      for (int i = 0; i < 4; i++) begin
        if (res_busy) seen++;
        @(negedge clk);
      end
      checkOutput($sformatf("cc%0d_busy", pass), 32'(seen), 32'd0);
      model_clear();
      issue(OP, 3'b010, 5'd0, 4, got, rd, wr, acc, rdy, waits);
      checkOutput($sformatf("cc%0d_status", pass), rd, 32'd0);
    end

    // Reset while scanning with an argmax request pending.
    m_sums = '{5, -3, 40, 40, 0, -7, 2, 1, 9};
    m_bits = 9'h1A5;
    applyStimulus(m_bits, pack_sums(), cap);
    pcpi_valid = 1'b1;
    pcpi_insn  = {17'd0, 3'b011, 5'd0, OP};
    seen  = 0;
    waits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (pcpi_ready) seen++;
      if (pcpi_wait) waits++;
    end
    checkOutput("mrst_waits_before", 32'(waits), 32'd4);
    rst = 1'b1;
    @(negedge clk);
    pcpi_valid = 1'b0;
    checkOutput("mrst_wr", {31'd0, pcpi_wr}, 32'd0);
    checkOutput("mrst_rd", pcpi_rd, 32'd0);
    checkOutput("mrst_wait", {31'd0, pcpi_wait}, 32'd0);
    checkOutput("mrst_ready", {31'd0, pcpi_ready}, 32'd0);
    checkOutput("mrst_busy", {31'd0, res_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pcpi_ready) seen++;
    end
    checkOutput("mrst_no_ready", 32'(seen), 32'd0);
    model_clear();
    issue(OP, 3'b011, 5'd0, 4, got, rd, wr, acc, rdy, waits);
    checkOutput("mrst_argmax_rd", rd, 32'd0);
    checkOutput("mrst_argmax_wr", {31'd0, wr}, 32'd1);

    // Randomized results, optional overrun, argmax at a random point in the scan.
    for (int it = 0; it < 20; it++) begin
      do_clear();
      for (int k = 0; k < 9; k++) begin
        if ($urandom_range(0, 1) == 1) m_sums[k] = int'($urandom_range(0, 6)) - 3;
        else m_sums[k] = int'($urandom);
      end
      m_bits = 9'($urandom);
      applyStimulus(m_bits, pack_sums(), cap);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 7)) @(negedge clk);
        for (int k = 0; k < 9; k++) junk[32*k +: 32] = $urandom;
        applyStimulus(9'($urandom), junk, dummy);
        m_overrun = 1'b1;
      end
      repeat ($urandom_range(0, 12)) @(negedge clk);
      issue(OP, 3'b011, 5'd0, 20, got, rd, wr, acc, rdy, waits);
      exp_rdy = (acc > cap + 9) ? acc : cap + 9;
      checkOutput($sformatf("rnd%0d_argmax", it), rd, exp_argmax());
      checkOutput($sformatf("rnd%0d_wr", it), {31'd0, wr}, 32'd1);
      checkOutput($sformatf("rnd%0d_rdy_at", it), 32'(rdy), 32'(exp_rdy));
      checkOutput($sformatf("rnd%0d_waits", it), 32'(waits), 32'(exp_rdy - acc));
      dummy = int'($urandom_range(0, 15));
      issue(OP, 3'b001, 5'(dummy), 4, got, rd, wr, acc, rdy, waits);
      checkOutput($sformatf("rnd%0d_sum", it), rd, exp_sum(dummy));
      issue(OP, 3'b010, 5'd0, 4, got, rd, wr, acc, rdy, waits);
      checkOutput($sformatf("rnd%0d_status", it), rd, exp_status());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
